// File: rtl/game_regfile_pkg.sv
// game_regfile shared constants: widths, register map indices,
// LFSR seed and taps, plus the LFSR next-state helper.
package game_regfile_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned RAND_REG   = 29;
  localparam int unsigned SCREEN_REG = 30;
  localparam int unsigned X_BASE     = 1;
  localparam int unsigned Y_BASE     = 9;
  localparam int unsigned NUM_OBJ    = 8;

  localparam logic [31:0] RAND_SEED = 32'h0000_0001;

  localparam int unsigned LFSR_T0 = 31;
  localparam int unsigned LFSR_T1 = 21;
  localparam int unsigned LFSR_T2 = 1;
  localparam int unsigned LFSR_T3 = 0;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0],
            s[LFSR_T0] ^ s[LFSR_T1] ^ s[LFSR_T2] ^ s[LFSR_T3]};
  endfunction

endpackage

// File: rtl/game_regfile_if.sv
// CPU-side register file bus: one write port, two read ports.
// master = datapath (drives indices/data), slave = register file.
interface game_regfile_if;
  import game_regfile_pkg::*;

  logic              ctrl_writeEn;
  logic [4:0]        ctrl_writeReg;
  logic [4:0]        ctrl_readRegA;
  logic [4:0]        ctrl_readRegB;
  logic [DATA_W-1:0] data_writeReg;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;

  modport master (
    output ctrl_writeEn, ctrl_writeReg,
    output ctrl_readRegA, ctrl_readRegB,
    output data_writeReg,
    input  data_readRegA, data_readRegB
  );

  modport slave (
    input  ctrl_writeEn, ctrl_writeReg,
    input  ctrl_readRegA, ctrl_readRegB,
    input  data_writeReg,
    output data_readRegA, data_readRegB
  );

endinterface

// File: rtl/game_regfile_lfsr32.sv
// lfsr32: 32-bit Fibonacci LFSR, seed on reset, advances when i_en.
// Ports: clk, rst (async high), i_en, o_q (current state).
module lfsr32
  import game_regfile_pkg::*;
#(
  parameter logic [31:0] SEED = RAND_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic [31:0] o_q
);

  logic [31:0] r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign o_q = r_state;

endmodule

// File: rtl/game_regfile.sv
// game_regfile: 32x32 register file, 2 comb reads, 1 sync write.
// Ports: clock, ctrl_reset (async high), bus (game_regfile_if.slave),
//   screenEndVal -> r30 each edge, reg_*_x/y/rand live exports.
// Macro RAND_REG_EN: r29 becomes a free-running LFSR (read-only).
module game_regfile #(
  parameter int unsigned DATA_W     = game_regfile_pkg::DATA_W,
  parameter int unsigned RAND_REG   = game_regfile_pkg::RAND_REG,
  parameter int unsigned SCREEN_REG = game_regfile_pkg::SCREEN_REG,
  parameter logic [31:0] RAND_SEED  = game_regfile_pkg::RAND_SEED
) (
  input  logic              clock,
  input  logic              ctrl_reset,
  game_regfile_if.slave     bus,
  input  logic [DATA_W-1:0] screenEndVal,
  output logic [DATA_W-1:0] reg_1_x,
  output logic [DATA_W-1:0] reg_2_x,
  output logic [DATA_W-1:0] reg_3_x,
  output logic [DATA_W-1:0] reg_4_x,
  output logic [DATA_W-1:0] reg_5_x,
  output logic [DATA_W-1:0] reg_6_x,
  output logic [DATA_W-1:0] reg_7_x,
  output logic [DATA_W-1:0] reg_8_x,
  output logic [DATA_W-1:0] reg_9_y,
  output logic [DATA_W-1:0] reg_10_y,
  output logic [DATA_W-1:0] reg_11_y,
  output logic [DATA_W-1:0] reg_12_y,
  output logic [DATA_W-1:0] reg_13_y,
  output logic [DATA_W-1:0] reg_14_y,
  output logic [DATA_W-1:0] reg_15_y,
  output logic [DATA_W-1:0] reg_16_y,
  output logic [DATA_W-1:0] reg_29_rand
);

  import game_regfile_pkg::*;

  localparam logic [4:0] L_SCR = 5'(SCREEN_REG);
  localparam logic [4:0] L_RND = 5'(RAND_REG);

  logic [DATA_W-1:0] r_regs [0:31];
  logic [DATA_W-1:0] w_rf   [0:31];
  logic              w_wr_ok;

  // r30 is owned by the display; r29 is owned by the LFSR when built.
`ifdef RAND_REG_EN
  assign w_wr_ok = bus.ctrl_writeEn
                && (bus.ctrl_writeReg != 5'd0)
                && (bus.ctrl_writeReg != L_SCR)
                && (bus.ctrl_writeReg != L_RND);
`else
  assign w_wr_ok = bus.ctrl_writeEn
                && (bus.ctrl_writeReg != 5'd0)
                && (bus.ctrl_writeReg != L_SCR);
`endif

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (w_wr_ok) begin
        r_regs[bus.ctrl_writeReg] <= bus.data_writeReg;
      end
      r_regs[SCREEN_REG] <= screenEndVal;
    end
  end

`ifdef RAND_REG_EN
  logic [31:0] w_lfsr;

  lfsr32 #(
    .SEED (RAND_SEED)
  ) u_lfsr (
    .clk  (clock),
    .rst  (ctrl_reset),
    .i_en (1'b1),
    .o_q  (w_lfsr)
  );
`else
  // Seed only matters when the LFSR is built.
  logic [31:0] w_unused_seed;
  assign w_unused_seed = RAND_SEED;
`endif

  // Visible register view: r0 forced to zero, r29 from LFSR if built.
  always_comb begin
    w_rf = r_regs;
    w_rf[0] = '0;
`ifdef RAND_REG_EN
    w_rf[RAND_REG] = w_lfsr;
`endif
  end

  assign bus.data_readRegA = w_rf[bus.ctrl_readRegA];
  assign bus.data_readRegB = w_rf[bus.ctrl_readRegB];

  assign reg_1_x  = w_rf[X_BASE + 0];
  assign reg_2_x  = w_rf[X_BASE + 1];
  assign reg_3_x  = w_rf[X_BASE + 2];
  assign reg_4_x  = w_rf[X_BASE + 3];
  assign reg_5_x  = w_rf[X_BASE + 4];
  assign reg_6_x  = w_rf[X_BASE + 5];
  assign reg_7_x  = w_rf[X_BASE + 6];
  assign reg_8_x  = w_rf[X_BASE + NUM_OBJ - 1];

  assign reg_9_y  = w_rf[Y_BASE + 0];
  assign reg_10_y = w_rf[Y_BASE + 1];
  assign reg_11_y = w_rf[Y_BASE + 2];
  assign reg_12_y = w_rf[Y_BASE + 3];
  assign reg_13_y = w_rf[Y_BASE + 4];
  assign reg_14_y = w_rf[Y_BASE + 5];
  assign reg_15_y = w_rf[Y_BASE + 6];
  assign reg_16_y = w_rf[Y_BASE + NUM_OBJ - 1];

  assign reg_29_rand = w_rf[RAND_REG];

endmodule

// File: tb/tb_game_regfile.sv
// tb_game_regfile: scoreboard bench for game_regfile.
// Expected values queued on stimulus, popped when outputs are sampled.
module tb_game_regfile;
  import game_regfile_pkg::*;

  logic        clock = 1'b0;
  logic        ctrl_reset = 1'b0;
  logic [31:0] screenEndVal = '0;

  logic [31:0] reg_1_x, reg_2_x, reg_3_x, reg_4_x;
  logic [31:0] reg_5_x, reg_6_x, reg_7_x, reg_8_x;
  logic [31:0] reg_9_y, reg_10_y, reg_11_y, reg_12_y;
  logic [31:0] reg_13_y, reg_14_y, reg_15_y, reg_16_y;
  logic [31:0] reg_29_rand;

  game_regfile_if bus();

  game_regfile dut (
    .clock        (clock),
    .ctrl_reset   (ctrl_reset),
    .bus          (bus),
    .screenEndVal (screenEndVal),
    .reg_1_x      (reg_1_x),
    .reg_2_x      (reg_2_x),
    .reg_3_x      (reg_3_x),
    .reg_4_x      (reg_4_x),
    .reg_5_x      (reg_5_x),
    .reg_6_x      (reg_6_x),
    .reg_7_x      (reg_7_x),
    .reg_8_x      (reg_8_x),
    .reg_9_y      (reg_9_y),
    .reg_10_y     (reg_10_y),
    .reg_11_y     (reg_11_y),
    .reg_12_y     (reg_12_y),
    .reg_13_y     (reg_13_y),
    .reg_14_y     (reg_14_y),
    .reg_15_y     (reg_15_y),
    .reg_16_y     (reg_16_y),
    .reg_29_rand  (reg_29_rand)
  );

  always #5 clock = ~clock;

`ifdef RAND_REG_EN
  localparam logic [31:0] R29_RST = 32'h0000_0001;
  localparam logic [31:0] R29_E1  = 32'h0000_0003;
  localparam logic [31:0] R29_E2  = 32'h0000_0006;
  localparam logic [31:0] R29_WD  = 32'h0000_0000;
  localparam logic [31:0] R29_E3  = 32'h0000_000D;
`else
  localparam logic [31:0] R29_RST = 32'h0000_0000;
  localparam logic [31:0] R29_E1  = 32'h0000_0000;
  localparam logic [31:0] R29_E2  = 32'h0000_0000;
  localparam logic [31:0] R29_WD  = 32'h0000_005A;
  localparam logic [31:0] R29_E3  = 32'h0000_005A;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] sb_q [$];
  string       tag_q [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %08h want %08h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    tag_q.push_back(tag);
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    t = tag_q.pop_front();
    e = sb_q.pop_front();
    chk(t, obs, e);
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    input logic [31:0] ea, input logic [31:0] eb);
    bus.ctrl_readRegA = a;
    bus.ctrl_readRegB = b;
    sb_push($sformatf("rdA_r%0d", a), ea);
    sb_push($sformatf("rdB_r%0d", b), eb);
    #1;
    sb_pop(bus.data_readRegA);
    sb_pop(bus.data_readRegB);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    bus.ctrl_writeEn  = 1'b1;
    bus.ctrl_writeReg = a;
    bus.data_writeReg = d;
    @(negedge clock);
    bus.ctrl_writeEn  = 1'b0;
  endtask

  initial begin
    bus.ctrl_writeEn  = 1'b0;
    bus.ctrl_writeReg = '0;
    bus.ctrl_readRegA = '0;
    bus.ctrl_readRegB = '0;
    bus.data_writeReg = '0;

    #1 ctrl_reset = 1'b1;
    #1;
    rd(5'd1, 5'd16, 32'h0, 32'h0);
    rd(5'd31, 5'd31, 32'h0, 32'h0);
    sb_push("rst_r29", R29_RST);
    sb_pop(reg_29_rand);
    sb_push("rst_x1", 32'h0);
    sb_pop(reg_1_x);

    @(negedge clock);
    ctrl_reset = 1'b0;
    @(negedge clock);
    sb_push("r29_e1", R29_E1);
    sb_pop(reg_29_rand);
    @(negedge clock);
    sb_push("r29_e2", R29_E2);
    sb_pop(reg_29_rand);
    bus.ctrl_writeEn  = 1'b1;
    bus.ctrl_writeReg = 5'd29;
    bus.data_writeReg = R29_WD;
    @(negedge clock);
    bus.ctrl_writeEn  = 1'b0;
    sb_push("r29_wr", R29_E3);
    sb_pop(reg_29_rand);

    wr(5'd7, 32'h0000_00A5);
    wr(5'd13, 32'hFFFF_FFFF);
    rd(5'd7, 5'd13, 32'h0000_00A5, 32'hFFFF_FFFF);
    sb_push("x7", 32'h0000_00A5);
    sb_pop(reg_7_x);
    sb_push("y13", 32'hFFFF_FFFF);
    sb_pop(reg_13_y);

    wr(5'd0, 32'h0000_1234);
    rd(5'd0, 5'd0, 32'h0, 32'h0);

    wr(5'd3, 32'd55);
    @(negedge clock);
    bus.ctrl_writeReg = 5'd3;
    bus.data_writeReg = 32'd99;
    @(negedge clock);
    rd(5'd3, 5'd3, 32'd55, 32'd55);
    sb_push("x3", 32'd55);
    sb_pop(reg_3_x);

    wr(5'd31, 32'hCAFE_F00D);
    wr(5'd28, 32'h1357_9BDF);
    rd(5'd31, 5'd28, 32'hCAFE_F00D, 32'h1357_9BDF);
    wr(5'd16, 32'h8000_0001);
    sb_push("y16", 32'h8000_0001);
    sb_pop(reg_16_y);

    @(negedge clock);
    bus.ctrl_writeEn  = 1'b1;
    bus.ctrl_writeReg = 5'd5;
    bus.data_writeReg = 32'd77;
    rd(5'd5, 5'd5, 32'd0, 32'd0);
    @(negedge clock);
    bus.ctrl_writeEn  = 1'b0;
    rd(5'd5, 5'd7, 32'd77, 32'h0000_00A5);

    @(negedge clock);
    screenEndVal      = 32'd1;
    bus.ctrl_writeEn  = 1'b1;
    bus.ctrl_writeReg = 5'd30;
    bus.data_writeReg = 32'h0000_DEAD;
    rd(5'd30, 5'd30, 32'd0, 32'd0);
    @(negedge clock);
    bus.ctrl_writeEn  = 1'b0;
    rd(5'd30, 5'd30, 32'd1, 32'd1);

    @(negedge clock);
    #2 ctrl_reset = 1'b1;
    #1;
    rd(5'd7, 5'd3, 32'h0, 32'h0);
    sb_push("arst_y13", 32'h0);
    sb_pop(reg_13_y);
    sb_push("arst_r29", R29_RST);
    sb_pop(reg_29_rand);
    rd(5'd30, 5'd31, 32'h0, 32'h0);
    @(negedge clock);
    ctrl_reset = 1'b0;

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_regfile.md
Name: game_regfile

Overview:
- 32-entry × 32-bit CPU register file with two combinational read ports and one synchronous write port.
- It sits between the processor datapath and the game display/logic.
- Registers 1–8 (x coordinates) and 9–16 (y coordinates) are exported continuously to the renderer.
- Register 30 tracks the screen-end flag from the display.
- Register 29 is a free-running pseudo-random source.

Parameters:
- DATA_W, 32, register width in bits.
- RAND_REG, 29, index of the random-number register.
- SCREEN_REG, 30, index of the screen-end status register.
- RAND_SEED, 32'h0000_0001, LFSR reset value (must be nonzero).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- ctrl_reset  in  1  asynchronous, active-high reset.
- ctrl_writeEn  in  1  write enable.
- ctrl_writeReg  in  5  write register index.
- ctrl_readRegA  in  5  read port A index.
- ctrl_readRegB  in  5  read port B index.
- data_writeReg  in  32  write data.
- data_readRegA  out  32  read port A data.
- data_readRegB  out  32  read port B data.
- screenEndVal  in  32  screen-end status from display logic.
- reg_1_x … reg_8_x  out  32 each  live contents of r1..r8.
- reg_9_y … reg_16_y  out  32 each  live contents of r9..r16.
- reg_29_rand  out  32  live contents of r29.

Behaviour:
- Reset: ctrl_reset high clears r1..r28 and r31 to 0 and r30 to 0, and loads r29 with RAND_SEED.
  - Reset acts immediately (asynchronous) and has priority over everything, including mid-write.
  - All outputs reflect the reset values combinationally.
- r0 is hardwired to 0; writes to index 0 are discarded.
- Write: on a rising clock edge with ctrl_writeEn=1, data_writeReg is stored in r[ctrl_writeReg], for indices 1–28 and 31.
  - Writes to SCREEN_REG are ignored.
  - Writes to RAND_REG are ignored when the random feature is enabled (see Optional Feature).
- Read: data_readRegA/B = r[ctrl_readRegA/B], purely combinational.
  - No write-to-read bypass: a value written at edge N is visible on the read ports only after edge N.
  - Both ports may read the same index simultaneously.
- SCREEN_REG: on every rising edge (when not in reset), r30 <= screenEndVal, independent of ctrl_writeEn. One-cycle latency from input to readback.
- Export outputs reg_*: a direct combinational view of the stored registers, same timing as the read ports.
- Index decode: 5-bit indices cover all 32 entries; there are no out-of-range cases.

Optional Feature:
- Macro: RAND_REG_EN.
- Defined:
  - r29 is a 32-bit Fibonacci LFSR that advances on every rising edge (not in reset): r29 <= {r29[30:0], r29[31]^r29[21]^r29[1]^r29[0]}.
  - CPU writes to r29 are ignored.
  - Reset value is RAND_SEED.
- Undefined:
  - r29 is an ordinary writable register with reset value 0.
  - reg_29_rand still exports it.

Decomposition:
- Shared package game_regfile_pkg holds:
  - DATA_W;
  - register-index constants: RAND_REG=29, SCREEN_REG=30, X_BASE=1, Y_BASE=9, NUM_OBJ=8;
  - RAND_SEED;
  - the LFSR tap positions.
- One sub-module is natural: lfsr32, holding the 32-bit LFSR with seed load and an advance enable. It is instantiated under RAND_REG_EN.

Test Plan:
- Reset: assert ctrl_reset, read r1, r16, r31 → all 0; reg_29_rand = 0x00000001 (RAND_REG_EN defined).
- Write and read: write r7=0x0000_00A5 and r13=0xFFFF_FFFF, then read A=7, B=13 → 0x000000A5 / 0xFFFFFFFF. reg_7_x and reg_13_y show the same values.
- r0 guard: write r0=0x1234 → read A=0 returns 0.
- writeEn low: write r3=55, then present r3=99 with ctrl_writeEn=0 → r3 still reads 55.
- Screen register: drive screenEndVal 0→1 with ctrl_writeEn=1 targeting r30 with 0xDEAD →
  - r30 reads 1 one edge after the change;
  - the CPU write has no effect.
- LFSR: from reset with seed 1 → r29 = 0x00000003 after 1 edge, 0x00000006 after 2 edges. A CPU write of 0 to r29 does not stop it.
- Async reset mid-run: pulse ctrl_reset between edges after nonzero writes → outputs clear before the next edge.
